// File: rtl/fp_wb_buf.sv
// fp_wb_buf -- floating-point writeback buffer.
//
// A small FIFO between the FP result datapath and the register-file
// writeback port. It holds the 64-bit result, the IEEE exception flags and
// the destination register tag. Both handshakes see only registered state:
//   - ready_o is derived from the occupancy count alone.
//   - valid_o is derived from the occupancy count alone.
// There is no bypass, so an entry pushed at a clock edge is first visible
// on the outputs after that edge. A full buffer refuses a push even when a
// pop happens in the same cycle.
//
// Optional feature: define FP_WB_NANBOX_EN to NaN-box single-precision
// results (fmt_i == 0). Such entries are stored with bits [63:32] forced
// to all ones. Without the macro, every entry is stored unmodified.
//
// Parameters:
//   DEPTH    number of entries; must be a power of two and at least 2.
//
// Ports:
//   clock    rising-edge clock.
//   reset    asynchronous, active-high reset.
//   valid_i  upstream result is valid.
//   result_i raw FP result; a single-precision value sits in bits [31:0].
//   fmt_i    result format: 0 = single, 1 = double, 2/3 = reserved.
//   flags_i  exception flags {NV, DZ, OF, UF, NX}.
//   tag_i    destination register index.
//   ready_o  buffer can accept an entry this cycle.
//   valid_o  head entry is presented to writeback.
//   result_o head entry result (0 when empty).
//   flags_o  head entry flags (0 when empty).
//   tag_o    head entry tag (0 when empty).
//   ready_i  writeback consumes the head entry this cycle.
//   count_o  number of occupied entries.
module fp_wb_buf #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic [63:0]                result_i,
  input  logic [1:0]                 fmt_i,
  input  logic [4:0]                 flags_i,
  input  logic [4:0]                 tag_i,
  output logic                       ready_o,
  output logic                       valid_o,
  output logic [63:0]                result_o,
  output logic [4:0]                 flags_o,
  output logic [4:0]                 tag_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   r_res [DEPTH];
  logic [4:0]    r_flg [DEPTH];
  logic [4:0]    r_tag [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_data;

`ifdef FP_WB_NANBOX_EN
  assign w_data = (fmt_i == 2'd0) ? {32'hFFFF_FFFF, result_i[31:0]} : result_i;
`else
  logic w_fmt_unused;
  assign w_fmt_unused = ^fmt_i;
  assign w_data       = result_i;
`endif

  assign ready_o = (r_count != FULL);
  assign valid_o = (r_count != '0);
  assign count_o = r_count;

  assign w_push = valid_i & ready_o;
  assign w_pop  = valid_o & ready_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset. Stale data is unreachable once the count is cleared.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_res[r_wptr] <= w_data;
      r_flg[r_wptr] <= flags_i;
      r_tag[r_wptr] <= tag_i;
    end
  end

  assign result_o = valid_o ? r_res[r_rptr] : '0;
  assign flags_o  = valid_o ? r_flg[r_rptr] : '0;
  assign tag_o    = valid_o ? r_tag[r_rptr] : '0;

endmodule

// File: tb/tb_fp_wb_buf.sv
module tb_fp_wb_buf;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          valid_i;
  logic [63:0]   result_i;
  logic [1:0]    fmt_i;
  logic [4:0]    flags_i;
  logic [4:0]    tag_i;
  logic          ready_o;
  logic          valid_o;
  logic [63:0]   result_o;
  logic [4:0]    flags_o;
  logic [4:0]    tag_o;
  logic          ready_i;
  logic [CW-1:0] count_o;

  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
    logic [4:0]  t;
  } entry_t;

  entry_t q[$];
  int total = 0;
  int bad   = 0;

  fp_wb_buf #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .result_i(result_i),
    .fmt_i(fmt_i), .flags_i(flags_i), .tag_i(tag_i), .ready_o(ready_o),
    .valid_o(valid_o), .result_o(result_o), .flags_o(flags_o), .tag_o(tag_o),
    .ready_i(ready_i), .count_o(count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] exp_res(input logic [1:0] f, input logic [63:0] r);
`ifdef FP_WB_NANBOX_EN
    if (f == 2'd0) return {32'hFFFF_FFFF, r[31:0]};
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_state(input string name);
    chk({name, ":count"}, 64'(count_o), 64'(q.size()));
    chk({name, ":valid"}, 64'(valid_o), 64'(q.size() != 0));
    chk({name, ":ready"}, 64'(ready_o), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      chk({name, ":head_res"}, result_o, q[0].r);
      chk({name, ":head_flg"}, 64'(flags_o), 64'(q[0].f));
      chk({name, ":head_tag"}, 64'(tag_o), 64'(q[0].t));
    end else begin
      chk({name, ":empty_res"}, result_o, 64'd0);
      chk({name, ":empty_flg"}, 64'(flags_o), 64'd0);
      chk({name, ":empty_tag"}, 64'(tag_o), 64'd0);
    end
  endtask

  // One clock: model the handshake from the scoreboard, compare the departing
  // head against the scoreboard, then check state #1 after the edge.
  task automatic tick(input string name);
    bit   do_push, do_pop;
    entry_t e;
    do_push = valid_i && (q.size() < DEPTH);
    do_pop  = ready_i && (q.size() != 0);
    if (do_pop) begin
      e = q.pop_front();
      chk({name, ":pop_res"}, result_o, e.r);
      chk({name, ":pop_flg"}, 64'(flags_o), 64'(e.f));
      chk({name, ":pop_tag"}, 64'(tag_o), 64'(e.t));
    end
    if (do_push) begin
      e.r = exp_res(fmt_i, result_i);
      e.f = flags_i;
      e.t = tag_i;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    chk_state(name);
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [1:0] f,
                       input logic [4:0] fl, input logic [4:0] t);
    valid_i = v; result_i = r; fmt_i = f; flags_i = fl; tag_i = t;
  endtask

  task automatic drain(input string name);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick(name);
    chk({name, ":drained"}, 64'(count_o), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    ready_i = 1'b0;
    drive(1'b0, 64'd0, 2'd0, 5'd0, 5'd0);
    #2;
    chk_state("reset");
    #10;
    reset = 1'b0;

    // First push right after reset, single-precision result.
    ready_i = 1'b1;
    drive(1'b1, 64'h0000_0000_BF80_0000, 2'd0, 5'd1, 5'd3);
    tick("sp_push");
    chk("sp_tag", 64'(tag_o), 64'd3);
`ifdef FP_WB_NANBOX_EN
    chk("sp_result", result_o, 64'hFFFF_FFFF_BF80_0000);
`else
    chk("sp_result", result_o, 64'h0000_0000_BF80_0000);
`endif
    drive(1'b0, 64'd0, 2'd0, 5'd0, 5'd0);
    tick("sp_pop");

    // Double-precision result passes through untouched.
    drive(1'b1, 64'h8000_0000_0000_0001, 2'd1, 5'd4, 5'd7);
    tick("dp_push");
    chk("dp_result", result_o, 64'h8000_0000_0000_0001);
    drain("dp_drain");

    // Fill with writeback stalled; fifth push refused.
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {32'h1234_0000, 32'(i)}, 2'(i % 4), 5'(i + 1), 5'(10 + i));
      tick("fill");
    end
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(ready_o), 64'd0);
    chk("full_head", 64'(tag_o), 64'd10);

    // Release writeback while still pushing: pop-only first, then steady 3.
    ready_i = 1'b1;
    drive(1'b1, 64'hAAAA_0000_0000_0020, 2'd1, 5'd2, 5'd20);
    tick("rel0");
    chk("rel0_count", 64'(count_o), 64'd3);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 64'hAAAA_0000_0000_0020 + 64'(i), 2'd1, 5'(i), 5'(20 + i));
      tick("steady");
      chk("steady_count", 64'(count_o), 64'd3);
    end
    drain("rel_drain");

    // Tags 0..9 with random writeback stalls; pointers wrap twice.
    begin
      int n = 0;
      int guard = 0;
      while (n < 10 && guard < 200) begin
        ready_i = 1'($urandom_range(0, 1));
        drive(1'b1, {$urandom, $urandom}, 2'd1, 5'($urandom_range(0, 31)), 5'(n));
        if (q.size() < DEPTH) n++;
        tick("rand");
        guard++;
      end
      if (n < 10) chk("rand_budget", 64'(n), 64'd10);
    end
    drain("rand_drain");

    // Asynchronous reset mid-cycle with two entries buffered.
    ready_i = 1'b0;
    drive(1'b1, 64'h5555, 2'd1, 5'd1, 5'd30);
    tick("pre_rst0");
    drive(1'b1, 64'h6666, 2'd1, 5'd2, 5'd31);
    tick("pre_rst1");
    chk("pre_rst_count", 64'(count_o), 64'd2);
    valid_i = 1'b0;
    #3;
    reset = 1'b1;
    q.delete();
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    chk("arst_res", result_o, 64'd0);
    #1;
    reset = 1'b0;
    ready_i = 1'b1;
    tick("post_rst_idle");
    tick("post_rst_idle2");

    // First push after reset is accepted, and only it emerges.
    drive(1'b1, 64'h0000_0000_3F80_0000, 2'd0, 5'd8, 5'd9);
    tick("post_rst_push");
    chk("post_rst_tag", 64'(tag_o), 64'd9);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
